// File: rtl/pool_engine.sv
// rtl/pool_engine.sv - 2x2 stride-2 max/average pooling engine between BRAM feature maps
//
// Walks every channel of an IN_H x IN_W x CHANNELS map held in a 1-cycle-latency
// input BRAM. Each non-overlapping 2x2 window is reduced by signed max or
// floor-average, with optional ReLU, and written to the result BRAM.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pool_en             start request, sampled only while idle
//   mode                0 = max, 1 = average (captured at start)
//   relu_en             clamp negative results to 0 (captured at start)
//   in_rd_en/in_addr    input BRAM read port; in_data valid one cycle later
//   out_wr_en/out_addr/out_data  result BRAM write port
//   busy                high from the first read through the finish cycle
//   pool_finish         one-cycle completion pulse
module pool_engine #(
    parameter int DATA_SIZE = 16,
    parameter int IN_H      = 28,
    parameter int IN_W      = 28,
    parameter int CHANNELS  = 6,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_en,
    input  logic                 mode,
    input  logic                 relu_en,
    output logic                 in_rd_en,
    output logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 out_wr_en,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 pool_finish
);

    localparam int OH    = IN_H / 2;
    localparam int OW    = IN_W / 2;
    localparam int NWIN  = CHANNELS * OH * OW;
    localparam int SUM_W = DATA_SIZE + 2;

    localparam logic [ADDR_W-1:0] LAST_WIN  = ADDR_W'(NWIN - 1);
    localparam logic [ADDR_W-1:0] OCOL_LAST = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] ROW_W     = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] ROW_SKIP  = ADDR_W'(IN_W + 2);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    generate
        if ((IN_H % 2) != 0 || (IN_W % 2) != 0) begin : g_odd_dims
            $error("pool_engine: IN_H and IN_W must both be even");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_WR, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                        r_mode;
    logic                        r_relu;
    logic [ADDR_W-1:0]           r_base;      // top-left input address of current window
    logic [ADDR_W-1:0]           r_out_addr;  // output address == window index
    logic [ADDR_W-1:0]           r_ocol;
    logic signed [DATA_SIZE-1:0] r_max;
    logic signed [SUM_W-1:0]     r_sum;

    logic                        w_start;
    logic                        w_last_win;
    logic signed [DATA_SIZE-1:0] w_sample;
    logic signed [SUM_W-1:0]     w_sample_ext;
    logic signed [DATA_SIZE-1:0] w_avg;
    logic signed [DATA_SIZE-1:0] w_pooled;
    logic signed [DATA_SIZE-1:0] w_result;
    logic                        w_unused_sum_lsbs;

    assign w_start      = (r_state == S_IDLE) && pool_en;
    assign w_last_win   = (r_out_addr == LAST_WIN);
    assign w_sample     = $signed(in_data);
    assign w_sample_ext = {{2{w_sample[DATA_SIZE-1]}}, w_sample};

    // Dropping the two LSBs of the 18-bit sum is the arithmetic shift by 2
    // (floor toward -inf); the remaining bits always fit in DATA_SIZE.
    assign w_avg             = r_sum[SUM_W-1:2];
    assign w_unused_sum_lsbs = ^r_sum[1:0];
    assign w_pooled          = r_mode ? w_avg : r_max;
    assign w_result          = (r_relu && w_pooled[DATA_SIZE-1]) ? '0 : w_pooled;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (pool_en) w_next = S_RD0;
            S_RD0:   w_next = S_RD1;
            S_RD1:   w_next = S_RD2;
            S_RD2:   w_next = S_RD3;
            S_RD3:   w_next = S_WAIT;
            S_WAIT:  w_next = S_WR;
            S_WR:    w_next = w_last_win ? S_DONE : S_RD0;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: configuration latch, window accumulators, address counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_relu     <= 1'b0;
            r_base     <= '0;
            r_out_addr <= '0;
            r_ocol     <= '0;
            r_max      <= '0;
            r_sum      <= '0;
        end else begin
            if (w_start) begin
                r_mode     <= mode;
                r_relu     <= relu_en;
                r_base     <= '0;
                r_out_addr <= '0;
                r_ocol     <= '0;
            end

            // Data lags the read by one state: RD1 carries the first sample,
            // WAIT carries the fourth.
            if (r_state == S_RD1) begin
                r_max <= w_sample;
                r_sum <= w_sample_ext;
            end else if (r_state inside {S_RD2, S_RD3, S_WAIT}) begin
                if (w_sample > r_max) begin
                    r_max <= w_sample;
                end
                r_sum <= r_sum + w_sample_ext;
            end

            // Past the last column the base skips the odd row below, which
            // also lands exactly on the next channel after its last row pair.
            if (r_state == S_WR) begin
                r_out_addr <= r_out_addr + ONE;
                if (r_ocol == OCOL_LAST) begin
                    r_ocol <= '0;
                    r_base <= r_base + ROW_SKIP;
                end else begin
                    r_ocol <= r_ocol + ONE;
                    r_base <= r_base + COL_STEP;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        in_rd_en    = 1'b0;
        in_addr     = '0;
        out_wr_en   = 1'b0;
        out_addr    = '0;
        out_data    = '0;
        busy        = (r_state != S_IDLE);
        pool_finish = 1'b0;
        case (r_state)
            S_RD0: begin
                in_rd_en = 1'b1;
                in_addr  = r_base;
            end
            S_RD1: begin
                in_rd_en = 1'b1;
                in_addr  = r_base + ONE;
            end
            S_RD2: begin
                in_rd_en = 1'b1;
                in_addr  = r_base + ROW_W;
            end
            S_RD3: begin
                in_rd_en = 1'b1;
                in_addr  = r_base + ROW_W + ONE;
            end
            S_WR: begin
                out_wr_en = 1'b1;
                out_addr  = r_out_addr;
                out_data  = w_result;
            end
            S_DONE: begin
                pool_finish = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pool_engine.sv
// tb/tb_pool_engine.sv - randomized self-checking bench for pool_engine against a window-level model
module tb_pool_engine;

    localparam int IN_H    = 28;
    localparam int IN_W    = 28;
    localparam int CH      = 6;
    localparam int OH      = IN_H / 2;
    localparam int OW      = IN_W / 2;
    localparam int W       = CH * OH * OW;
    localparam int NIN     = CH * IN_H * IN_W;
    localparam int DONE_EL = 6 * W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pool_en = 1'b0;
    logic        mode = 1'b0;
    logic        relu_en = 1'b0;
    logic        in_rd_en;
    logic [15:0] in_addr;
    logic [15:0] in_data;
    logic        out_wr_en;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        pool_finish;
    logic [15:0] bram_q = '0;

    always #5 clk = ~clk;

    pool_engine #(
        .DATA_SIZE(16), .IN_H(IN_H), .IN_W(IN_W), .CHANNELS(CH), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .pool_en(pool_en), .mode(mode), .relu_en(relu_en),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .pool_finish(pool_finish)
    );

    logic signed [15:0] mem [NIN];
    int                 exp_res [W];
    logic signed [15:0] obs [W];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int start_cyc = 0;
    int nwr = 0;
    bit active = 1'b0;
    bit chk = 1'b0;
    int first_wr_el = -1;
    int fin_el = -1;
    int fin_cyc = -1;
    int rd0_cyc = -1;
    int el;
    bit was_active;

    // 1-cycle-latency input BRAM
    always @(posedge clk) begin
        if (in_rd_en) bram_q <= mem[in_addr];
    end
    assign in_data = bram_q;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int floor_div4(input int s);
        return (s >= 0) ? (s / 4) : -((-s + 3) / 4);
    endfunction

    // Golden pooled map from the current input memory
    task automatic compute_expected(input bit md, input bit rl);
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < OH; r++) begin
                for (int q = 0; q < OW; q++) begin
                    int b, v[4], res;
                    b = c * IN_H * IN_W + 2 * r * IN_W + 2 * q;
                    v[0] = mem[b];
                    v[1] = mem[b + 1];
                    v[2] = mem[b + IN_W];
                    v[3] = mem[b + IN_W + 1];
                    if (md) begin
                        res = floor_div4(v[0] + v[1] + v[2] + v[3]);
                    end else begin
                        res = v[0];
                        for (int k = 1; k < 4; k++) if (v[k] > res) res = v[k];
                    end
                    if (rl && res < 0) res = 0;
                    exp_res[c * OH * OW + r * OW + q] = res;
                end
            end
        end
    endtask

    function automatic int rd_addr(input int k, input int j);
        int c, rem, r, q;
        c   = k / (OH * OW);
        rem = k % (OH * OW);
        r   = rem / OW;
        q   = rem % OW;
        return c * IN_H * IN_W + (2 * r + j / 2) * IN_W + 2 * q + j % 2;
    endfunction

    // Run tracker: a run lasts 6*W+1 cycles from the start edge; pool_en is
    // only honoured once the engine has spent a cycle idle.
    always @(posedge clk) begin
        was_active = active;
        if (rst) begin
            active = 1'b0;
        end else if (active && (cyc - start_cyc) == DONE_EL) begin
            active = 1'b0;
        end else if (!was_active && pool_en) begin
            active      = 1'b1;
            start_cyc   = cyc;
            nwr         = 0;
            fin_el      = -1;
            first_wr_el = -1;
            compute_expected(mode, relu_en);
        end
        cyc = cyc + 1;
    end

    // Per-cycle compare
    always @(negedge clk) begin
        if (chk) begin
            el = cyc - start_cyc;
            if (active) begin
                check("busy", busy, 1);
                check("pool_finish", pool_finish, el == DONE_EL);
                check("in_rd_en", in_rd_en, (el <= 6 * W) && (((el - 1) % 6) < 4));
                check("out_wr_en", out_wr_en, (el <= 6 * W) && ((el % 6) == 0));
                if (el <= 6 * W && ((el - 1) % 6) < 4) begin
                    check("in_addr", in_addr, rd_addr((el - 1) / 6, (el - 1) % 6));
                    if (el == 1 && in_rd_en === 1'b1) rd0_cyc = cyc;
                end
                if (el <= 6 * W && (el % 6) == 0) begin
                    check("out_addr", out_addr, el / 6 - 1);
                    check("out_data", $signed(out_data), exp_res[el / 6 - 1]);
                end
                if (out_wr_en === 1'b1) begin
                    if (first_wr_el < 0) first_wr_el = el;
                    if (out_addr < W) obs[out_addr] = $signed(out_data);
                    nwr++;
                end
                if (pool_finish === 1'b1) begin
                    fin_el  = el;
                    fin_cyc = cyc;
                    check("writes_per_run", nwr, W);
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_finish", pool_finish, 0);
                check("idle_rd_en", in_rd_en, 0);
                check("idle_wr_en", out_wr_en, 0);
                check("idle_in_addr", in_addr, 0);
                check("idle_out_addr", out_addr, 0);
                check("idle_out_data", out_data, 0);
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < NIN; i++) mem[i] = 16'($urandom);
    endtask

    task automatic plant_literals();
        mem[0]   = -5;     mem[1]   = -3;     mem[28]  = -8;     mem[29]  = -1;
        mem[2]   = 32767;  mem[3]   = 32767;  mem[30]  = 32767;  mem[31]  = 32767;
        mem[4]   = -1;     mem[5]   = -2;     mem[32]  = -2;     mem[33]  = -2;
        mem[6]   = 1;      mem[7]   = 2;      mem[34]  = 2;      mem[35]  = 2;
        mem[784] = 100;    mem[785] = -200;   mem[812] = 300;    mem[813] = 50;
    endtask

    task automatic start_run(input bit md, input bit rl);
        @(negedge clk);
        mode    = md;
        relu_en = rl;
        pool_en = 1'b1;
        @(negedge clk);
        pool_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("finish_cycle", fin_el, DONE_EL);
        check("first_write_cycle", first_wr_el, 6);
    endtask

    function automatic int relu_of(input int v, input bit rl);
        return (rl && v < 0) ? 0 : v;
    endfunction

    // Hand-computed window results pin both the model and the DUT
    task automatic pin(input bit md, input bit rl);
        int e[5];
        int a[5];
        a[0] = 0; a[1] = 1; a[2] = 2; a[3] = 3; a[4] = 196;
        e[0] = relu_of(md ? -5 : -1, rl);
        e[1] = 32767;
        e[2] = relu_of(md ? -2 : -1, rl);
        e[3] = md ? 1 : 2;
        e[4] = md ? 62 : 300;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("model_lit_%0d", a[i]), exp_res[a[i]], e[i]);
            check($sformatf("dut_lit_%0d", a[i]), obs[a[i]], e[i]);
        end
    endtask

    initial begin
        int n;
        int first_fin;
        fill_random();
        plant_literals();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_run(1'b0, 1'b0);  wait_idle();  pin(1'b0, 1'b0);
        start_run(1'b0, 1'b1);  wait_idle();  pin(1'b0, 1'b1);
        start_run(1'b1, 1'b0);  wait_idle();  pin(1'b1, 1'b0);

        // Abort with reset at window 10, then restart from address 0
        fill_random();
        plant_literals();
        start_run(1'b1, 1'b1);
        n = 0;
        while (nwr < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_window10", nwr, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Mode/relu toggled and pool_en pulsed mid-run must be ignored
        start_run(1'b1, 1'b1);
        repeat (100) @(negedge clk);
        mode = 1'b0;
        relu_en = 1'b0;
        pool_en = 1'b1;
        @(negedge clk);
        pool_en = 1'b0;
        repeat (500) @(negedge clk);
        mode = 1'b1;
        pool_en = 1'b1;
        repeat (3) @(negedge clk);
        pool_en = 1'b0;
        mode = 1'b0;
        wait_idle();
        pin(1'b1, 1'b1);

        // pool_en held high: back-to-back runs with one idle cycle between
        fill_random();
        plant_literals();
        @(negedge clk);
        mode = 1'b0;
        relu_en = 1'b0;
        pool_en = 1'b1;
        @(negedge clk);
        wait_idle();
        first_fin = fin_cyc;
        @(negedge clk);
        pool_en = 1'b0;
        wait_idle();
        check("back_to_back_rd0_gap", rd0_cyc - first_fin, 2);
        pin(1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
